// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared types and default geometry for the FIFO word packer.
package fifo_pack_pkg;
  typedef enum logic {S_FILL, S_SEND} state_t;
  localparam int FIFO_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = FIFO_WIDTH * BYTES_PER_WORD;
endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains FIFO bytes into little-endian words on a valid/ready handshake,
// with flush forcing out a partial word.
module fifo_word_packer #(
  parameter int FIFO_WIDTH     = fifo_pack_pkg::FIFO_WIDTH,
  parameter int BYTES_PER_WORD = fifo_pack_pkg::BYTES_PER_WORD
) (
  input  logic                                   clk,
  input  logic                                   rst_,
  input  logic [FIFO_WIDTH-1:0]                  fifo_data_out,
  input  logic                                   fifo_empty,
  output logic                                   fifo_read,
  input  logic                                   flush,
  output logic [FIFO_WIDTH*BYTES_PER_WORD-1:0]   word_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]    word_bytes,
  output logic                                   word_valid,
  input  logic                                   word_ready
);
  import fifo_pack_pkg::*;
  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);
  state_t                                    r_state;
  logic [CW-1:0]                             r_issued;
  logic [CW-1:0]                             r_captured;
  logic                                      r_rd_pend;
  logic                                      r_flush_pend;
  logic [BYTES_PER_WORD-1:0][FIFO_WIDTH-1:0] r_lanes;
  logic                                      r_valid;
  logic [CW-1:0]                             r_bytes;
  logic [IW-1:0]                             w_lane;
  // rst_ gates the strobe so no read escapes while reset is asserted
  assign fifo_read  = (r_state == S_FILL) && !fifo_empty && (r_issued < FULL) && !r_flush_pend && rst_;
  assign w_lane     = r_captured[IW-1:0];
  assign word_data  = r_lanes;
  assign word_bytes = r_bytes;
  assign word_valid = r_valid;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= S_FILL;
      r_issued     <= '0;
      r_captured   <= '0;
      r_rd_pend    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_lanes      <= '0;
      r_valid      <= 1'b0;
      r_bytes      <= '0;
    end else begin
      r_rd_pend <= fifo_read;
      if (r_state == S_FILL) begin
        if (fifo_read) r_issued <= r_issued + 1'b1;
        if (flush && r_issued != '0) r_flush_pend <= 1'b1;
        if (r_rd_pend) begin
          r_lanes[w_lane] <= fifo_data_out;
          r_captured      <= r_captured + 1'b1;
        end
        // a flushed word waits for any in-flight byte before it is sent
        if (r_rd_pend && r_captured == LAST) begin
          r_state <= S_SEND;
          r_valid <= 1'b1;
          r_bytes <= FULL;
        end else if (r_flush_pend && !r_rd_pend) begin
          r_state <= S_SEND;
          r_valid <= 1'b1;
          r_bytes <= r_captured;
        end
      end else if (word_ready) begin
        r_state      <= S_FILL;
        r_issued     <= '0;
        r_captured   <= '0;
        r_flush_pend <= 1'b0;
        r_lanes      <= '0;
        r_valid      <= 1'b0;
        r_bytes      <= '0;
      end
    end
  end
endmodule
